aes128_top: RTL and testbench
=============================

# aes128_top

UART-attached AES-128 encryption engine (FIPS-197, encrypt only, ECB, one block per transaction). A serial host sends a 16-byte plaintext, then a 16-byte key, over one 8N1 UART line. The block encrypts iteratively and returns the 16-byte ciphertext on a second UART line. It is the top level of the AES-128 FPGA design and sits directly on the board UART pins.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range ≥ 4.
- `clk`  input  1  system clock, rising-edge; 100 MHz nominal.
- `rst`  input  1  reset; asynchronous and active-high (one clock; reset is asynchronous and active-high).
- `data_in`  input  1  UART RX line; idle high; 8N1, LSB first; synchronised internally through 2 flops.
- `data_out`  output  1  UART TX line; idle high; 8N1, LSB first.

## Operation
- Top FSM states: RX_PT, RX_KEY, ENC, TX, then back to RX_PT.
- RX_PT: collect 16 bytes. The first byte received is plaintext[127:120] and the last is [7:0].
- RX_KEY: collect 16 key bytes in the same big-endian byte order.
- ENC: iterative datapath, one AES round per clock.
  - Cycle 0: state = pt XOR key.
  - Cycles 1–9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Cycle 10: final round without MixColumns.
  - Round keys are expanded on the fly, one per cycle, using Rcon 01,02,04,08,10,20,40,80,1B,36.
  - S-box may be a ROM or GF(2^8) inversion plus affine transform; results must be identical.
- TX: send ciphertext byte [127:120] first through [7:0] last. Frames go back-to-back, 10 bit periods per byte.
- UART RX frame handling:
  - Start is detected on a falling edge of the synchronised line.
  - Every bit is sampled at mid-bit (CLKS_PER_BIT/2 after the edge, then every CLKS_PER_BIT).
  - If the stop bit samples 0 (framing error), the byte is discarded and the byte counter does not advance.
- Bytes arriving during ENC or TX are deframed but dropped.
- Key and plaintext registers are not retained between transactions; every block requires all 32 bytes.

## Timing
- Reset values:
  - `data_out` = 1.
  - FSM = RX_PT.
  - Byte counter = 0.
  - State, key and ciphertext registers = 0.
  - RX and TX bit counters = 0.
- Reset mid-operation (any state) aborts immediately. Partial bytes and blocks are lost and `data_out` returns high asynchronously.
- ENC is entered the cycle after the 32nd byte's stop bit is validated. Ciphertext is registered 11 cycles later.
- TX start bit is driven on the cycle after ENC completes.
- TX start bit, data bits and stop bit are each held exactly CLKS_PER_BIT cycles. There is no idle gap between bytes.
- RX returns to RX_PT on the cycle after the 16th TX stop bit completes.
- An RX start edge arriving mid-frame is ignored. The receiver re-arms only after the stop-bit sample.

## Configuration
- `AES128_RX_START_CHECK_EN`
  - Defined: the receiver re-samples the start bit at mid-bit. If the line is high, it is a false start: the receiver aborts and returns to idle, and no byte is produced.
  - Undefined: the falling edge alone commits the receiver to a full frame, and a glitch yields a byte (normally dropped by the stop-bit check).

## Test plan
- Reference vector:
  - pt 416476616E63656420456E6372797074, key 5468617473204D79204B756E67204675.
  - Required: 16 TX bytes 6f 5d db 7f 39 56 0b 0f e9 ea da 49 f8 7c 49 04, in order.
- FIPS-197 C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Two consecutive transactions (C.1 then reference) -> both ciphertexts correct. No state leaks from the first key.
- Framing error: send byte 3 of the plaintext with stop bit 0, then resend it correctly and complete the block -> correct ciphertext; the bad frame is not counted.
- Reset asserted after 20 RX bytes -> `data_out` high, no TX; a full fresh 32-byte transfer then yields the correct ciphertext.
- With `AES128_RX_START_CHECK_EN`: a 100-cycle low glitch on `data_in` -> no byte counted; the subsequent block encrypts correctly.

Source files
------------

// File: rtl/aes128_top.sv
// UART-attached AES-128 encryptor: 16 plaintext bytes then 16 key bytes in, 16 ciphertext bytes out.
// Optional macro AES128_RX_START_CHECK_EN rejects start bits that are high at mid-bit.
`timescale 1ns/1ps
module aes128_top #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic data_in,
   output logic data_out
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_PT, RX_KEY, ENC, TX} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as a^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // ---------------- UART receiver ----------------
   logic [1:0]    sync_reg;
   logic          rx_prev_reg;
   logic          rx_line;
   logic          rx_fall;
   logic          rx_busy_reg;
   logic [CW-1:0] rx_cnt_reg;
   logic [3:0]    rx_bit_reg;
   logic [7:0]    rx_shift_reg;
   logic          rx_valid_reg;

   assign rx_line = sync_reg[1];
   assign rx_fall = rx_prev_reg & ~rx_line;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg    <= 2'b11;
         rx_prev_reg <= 1'b1;
      end else begin
         sync_reg    <= {sync_reg[0], data_in};
         rx_prev_reg <= rx_line;
      end
   end

   // Bit 0 is the start bit (sampled half a bit in), 1..8 data, 9 the stop bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_busy_reg  <= 1'b0;
         rx_cnt_reg   <= '0;
         rx_bit_reg   <= 4'd0;
         rx_shift_reg <= 8'h00;
         rx_valid_reg <= 1'b0;
      end else begin
         rx_valid_reg <= 1'b0;
         if (!rx_busy_reg) begin
            if (rx_fall) begin
               rx_busy_reg <= 1'b1;
               rx_cnt_reg  <= '0;
               rx_bit_reg  <= 4'd0;
            end
         end else if (rx_cnt_reg == ((rx_bit_reg == 4'd0) ? HALF_LAST : BIT_LAST)) begin
            rx_cnt_reg <= '0;
            rx_bit_reg <= rx_bit_reg + 4'd1;
            if (rx_bit_reg == 4'd0) begin
`ifdef AES128_RX_START_CHECK_EN
               if (rx_line) rx_busy_reg <= 1'b0;
`endif
            end else if (rx_bit_reg == 4'd9) begin
               rx_busy_reg  <= 1'b0;
               rx_valid_reg <= rx_line;
            end else begin
               rx_shift_reg <= {rx_line, rx_shift_reg[7:1]};
            end
         end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
         end
      end
   end

   // ---------------- AES round datapath ----------------
   state_t        state_reg, state_next;
   logic [3:0]    byte_cnt_reg;
   logic [3:0]    round_reg;
   logic [127:0]  pt_reg, key_reg, rkey_reg, aes_state_reg, ct_reg;
   logic [CW-1:0] tx_cnt_reg;
   logic [3:0]    tx_bit_reg;
   logic          tx_line_reg;

   logic [127:0]  sb_out, sr_out, mc_out, rk_next, round_out;
   logic [31:0]   key_rot, key_t;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_sub
         localparam int ROW = gi % 4;
         localparam int COL = gi / 4;
         localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
         assign sb_out[127-8*gi -: 8] = sbox(aes_state_reg[127-8*gi -: 8]);
         assign sr_out[127-8*gi -: 8] = sb_out[127-8*SRC -: 8];
      end
      for (gi = 0; gi < 4; gi++) begin : g_mix
         assign mc_out[127-32*gi -: 32] = mix_col(sr_out[127-32*gi -: 32]);
      end
      for (gi = 0; gi < 4; gi++) begin : g_ksub
         assign key_t[31-8*gi -: 8] = sbox(key_rot[31-8*gi -: 8]) ^ ((gi == 0) ? rcon(round_reg) : 8'h00);
      end
   endgenerate

   assign key_rot = {rkey_reg[23:0], rkey_reg[31:24]};
   assign rk_next[127:96] = rkey_reg[127:96] ^ key_t;
   assign rk_next[95:64]  = rkey_reg[95:64]  ^ rk_next[127:96];
   assign rk_next[63:32]  = rkey_reg[63:32]  ^ rk_next[95:64];
   assign rk_next[31:0]   = rkey_reg[31:0]   ^ rk_next[63:32];

   assign round_out = ((round_reg == 4'd10) ? sr_out : mc_out) ^ rk_next;

   // ---------------- control ----------------
   logic tx_bit_done;
   assign tx_bit_done = (tx_cnt_reg == BIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= RX_PT;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RX_PT:   if (rx_valid_reg && byte_cnt_reg == 4'd15) state_next = RX_KEY;
         RX_KEY:  if (rx_valid_reg && byte_cnt_reg == 4'd15) state_next = ENC;
         ENC:     if (round_reg == 4'd10) state_next = TX;
         TX:      if (tx_bit_done && tx_bit_reg == 4'd9 && byte_cnt_reg == 4'd15) state_next = RX_PT;
         default: state_next = RX_PT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt_reg  <= 4'd0;
         round_reg     <= 4'd0;
         pt_reg        <= '0;
         key_reg       <= '0;
         rkey_reg      <= '0;
         aes_state_reg <= '0;
         ct_reg        <= '0;
         tx_cnt_reg    <= '0;
         tx_bit_reg    <= 4'd0;
         tx_line_reg   <= 1'b1;
      end else begin
         case (state_reg)
            RX_PT: if (rx_valid_reg) begin
               pt_reg       <= {pt_reg[119:0], rx_shift_reg};
               byte_cnt_reg <= byte_cnt_reg + 4'd1;
            end
            RX_KEY: if (rx_valid_reg) begin
               key_reg      <= {key_reg[119:0], rx_shift_reg};
               byte_cnt_reg <= byte_cnt_reg + 4'd1;
            end
            ENC: begin
               if (round_reg == 4'd0) begin
                  aes_state_reg <= pt_reg ^ key_reg;
                  rkey_reg      <= key_reg;
                  round_reg     <= 4'd1;
               end else begin
                  aes_state_reg <= round_out;
                  rkey_reg      <= rk_next;
                  round_reg     <= round_reg + 4'd1;
                  if (round_reg == 4'd10) begin
                     // Last round: latch ciphertext, drop inputs, launch the first start bit.
                     ct_reg      <= round_out;
                     round_reg   <= 4'd0;
                     pt_reg      <= '0;
                     key_reg     <= '0;
                     tx_cnt_reg  <= '0;
                     tx_bit_reg  <= 4'd0;
                     tx_line_reg <= 1'b0;
                  end
               end
            end
            TX: begin
               if (tx_bit_done) begin
                  tx_cnt_reg <= '0;
                  if (tx_bit_reg == 4'd9) begin
                     tx_bit_reg   <= 4'd0;
                     byte_cnt_reg <= byte_cnt_reg + 4'd1;
                     ct_reg       <= {ct_reg[119:0], 8'h00};
                     tx_line_reg  <= (byte_cnt_reg == 4'd15);
                  end else begin
                     tx_bit_reg  <= tx_bit_reg + 4'd1;
                     tx_line_reg <= (tx_bit_reg == 4'd8) ? 1'b1 : ct_reg[120 + tx_bit_reg[2:0]];
                  end
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign data_out = tx_line_reg;

endmodule

// File: tb/tb_aes128_top.sv
// Bench for aes128_top: known-answer table, framing/reset/drop sequences and random blocks
// checked against a table-based AES model.
`timescale 1ns/1ps
module tb_aes128_top;

   localparam int CPB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic data_in = 1'b1;
   logic data_out;

   always #5 clk = ~clk;

   aes128_top #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .data_in(data_in),
      .data_out(data_out)
   );

   typedef struct {
      logic [127:0] pt;
      logic [127:0] key;
      logic [127:0] ct;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   int gen = 0;
   int tx_frame_err = 0;
   logic [7:0] rx_q[$];

   logic [7:0] exp_t[256];
   logic [7:0] log_t[256];
   logic [7:0] sbox_t[256];

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
   endfunction

   task automatic init_tables();
      logic [7:0] p;
      logic [7:0] inv;
      logic [7:0] s;
      logic [7:0] c;
      p = 8'h01;
      c = 8'h63;
      for (int i = 0; i < 256; i++) log_t[i] = 8'h00;
      for (int i = 0; i < 255; i++) begin
         exp_t[i] = p;
         log_t[p] = i[7:0];
         p = p ^ xt(p);
      end
      exp_t[255] = exp_t[0];
      for (int x = 0; x < 256; x++) begin
         inv = (x == 0) ? 8'h00 : exp_t[(255 - int'(log_t[x])) % 255];
         for (int b = 0; b < 8; b++)
            s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ c[b];
         sbox_t[x] = s;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  w[44];
      logic [7:0]   st[16];
      logic [7:0]   tmp[16];
      logic [7:0]   a[4];
      logic [7:0]   rc;
      logic [31:0]  t;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) tmp[i] = sbox_t[st[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               st[4*c+row] = tmp[4*((c+row)%4)+row];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int j = 0; j < 4; j++) a[j] = st[4*c+j];
               for (int j = 0; j < 4; j++)
                  st[4*c+j] = gmul(8'h02, a[j]) ^ gmul(8'h03, a[(j+1)%4]) ^ a[(j+2)%4] ^ a[(j+3)%4];
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   // ---------------- checks ----------------
   task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // ---------------- UART host side ----------------
   task automatic bit_wait();
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      data_in = 1'b0;
      bit_wait();
      for (int i = 0; i < 8; i++) begin
         data_in = b[i];
         bit_wait();
      end
      data_in = stop;
      bit_wait();
      data_in = 1'b1;
      if (!stop) bit_wait();
   endtask

   task automatic send_block(input logic [127:0] pt, input logic [127:0] key);
      for (int i = 0; i < 16; i++) send_byte(pt[127-8*i -: 8], 1'b1);
      for (int i = 0; i < 16; i++) send_byte(key[127-8*i -: 8], 1'b1);
   endtask

   // Deframes data_out; frames cut by a reset (gen changed) are discarded.
   initial begin
      logic [7:0] b;
      int my_gen;
      forever begin
         @(negedge data_out);
         my_gen = gen;
         repeat (CPB / 2) @(negedge clk);
         if (data_out == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = data_out;
            end
            repeat (CPB) @(negedge clk);
            if (gen == my_gen) begin
               if (data_out !== 1'b1) tx_frame_err++;
               else rx_q.push_back(b);
            end
         end
      end
   end

   task automatic wait_tx(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (rx_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic collect(input string name, input logic [127:0] exp);
      bit ok;
      logic [127:0] ct;
      wait_tx(16, 20 * 10 * CPB + 200, ok);
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got %0d ciphertext bytes required 16 (timeout)", name, rx_q.size());
      end else begin
         ct = '0;
         for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = rx_q[i];
         check128(name, ct, exp);
      end
      repeat (2) bit_wait();
      rx_q.delete();
   endtask

   task automatic do_block(input string name, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp);
      rx_q.delete();
      send_block(pt, key);
      collect(name, exp);
   endtask

   task automatic do_reset();
      gen++;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rx_q.delete();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      vec_t tbl[3];
      logic [127:0] pt, key;
      bit ok;

      tbl[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      tbl[1] = '{128'h416476616E63656420456E6372797074, 128'h5468617473204D79204B756E67204675,
                 128'h6f5ddb7f39560b0fe9eada49f87c4904};
      tbl[2] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                 128'h3925841d02dc09fbdc118597196a0b32};

      init_tables();
      check128("model_kat", aes_ref(tbl[1].pt, tbl[1].key), tbl[1].ct);

      repeat (3) @(negedge clk);
      check_int("reset_data_out", int'(data_out), 1);
      rst = 1'b0;
      repeat (4 * CPB) @(negedge clk);
      check_int("idle_data_out", int'(data_out), 1);

      // Back-to-back known-answer blocks (C.1 followed by the reference vector).
      for (int i = 0; i < 3; i++) do_block($sformatf("kat_%0d", i), tbl[i].pt, tbl[i].key, tbl[i].ct);

      // Plaintext byte 3 first arrives with a bad stop bit, then correctly.
      rx_q.delete();
      for (int i = 0; i < 3; i++) send_byte(tbl[0].pt[127-8*i -: 8], 1'b1);
      send_byte(tbl[0].pt[103:96], 1'b0);
      for (int i = 3; i < 16; i++) send_byte(tbl[0].pt[127-8*i -: 8], 1'b1);
      for (int i = 0; i < 16; i++) send_byte(tbl[0].key[127-8*i -: 8], 1'b1);
      collect("framing_error", tbl[0].ct);

      // Reset after 20 received bytes, then a complete fresh transfer.
      rx_q.delete();
      for (int i = 0; i < 16; i++) send_byte(tbl[1].pt[127-8*i -: 8], 1'b1);
      for (int i = 0; i < 4; i++) send_byte(tbl[1].key[127-8*i -: 8], 1'b1);
      do_reset();
      check_int("reset20_data_out", int'(data_out), 1);
      repeat (30 * CPB) @(negedge clk);
      check_int("reset20_no_tx", rx_q.size(), 0);
      do_block("reset20_fresh", tbl[1].pt, tbl[1].key, tbl[1].ct);

      // Random blocks against the model.
      for (int n = 0; n < 3; n++) begin
         pt  = {$urandom, $urandom, $urandom, $urandom};
         key = {$urandom, $urandom, $urandom, $urandom};
         do_block($sformatf("rand_%0d", n), pt, key, aes_ref(pt, key));
      end

      // Bytes sent while the ciphertext is going out must be ignored.
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      rx_q.delete();
      send_block(pt, key);
      wait_tx(1, 20 * 10 * CPB, ok);
      send_byte(8'ha5, 1'b1);
      send_byte(8'h3c, 1'b1);
      collect("drop_during_tx", aes_ref(pt, key));
      do_block("after_drop", tbl[2].pt, tbl[2].key, tbl[2].ct);

      // Asynchronous reset while a zero bit is on the TX line.
      rx_q.delete();
      send_block(tbl[0].pt, tbl[0].key);
      wait_tx(2, 20 * 10 * CPB, ok);
      for (int cyc = 0; cyc < 20 * CPB; cyc++) begin
         @(negedge clk);
         if (data_out == 1'b0) break;
      end
      gen++;
      rst = 1'b1;
      #1;
      check_int("async_reset_data_out", int'(data_out), 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rx_q.delete();
      repeat (20 * CPB) @(negedge clk);
      check_int("async_reset_no_tx", rx_q.size(), 0);
      do_block("after_async_reset", tbl[0].pt, tbl[0].key, tbl[0].ct);

`ifdef AES128_RX_START_CHECK_EN
      // A short low glitch must not produce a byte.
      data_in = 1'b0;
      repeat (2) @(negedge clk);
      data_in = 1'b1;
      repeat (2) bit_wait();
      do_block("after_glitch", tbl[1].pt, tbl[1].key, tbl[1].ct);
`endif

      check_int("tx_framing", tx_frame_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
